// File: rtl/loop_scan_ctrl.sv
// Purpose: walks a 2-D (row outer, column inner) index space, one element per cycle.
// Latency: first element 1 cycle after an accepted start; done 1 cycle after the last element is consumed.
// Backpressure: stall holds the current element; nothing advances until stall is low.
// Optional abort input enabled by defining LOOP_SCAN_ABORT_EN.
module loop_scan_ctrl #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] row_max,
    input  logic [COL_W-1:0] col_max,
    input  logic             stall,
`ifdef LOOP_SCAN_ABORT_EN
    input  logic             abort,
`endif
    output logic [ROW_W-1:0] r,
    output logic [COL_W-1:0] c,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [COL_W-1:0] c_q, c_d;
    logic [ROW_W-1:0] row_max_q, row_max_d;
    logic [COL_W-1:0] col_max_q, col_max_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [ROW_W-1:0] r_inc;
    logic [COL_W-1:0] c_inc;
    logic             abort_req;

    // Incremented indices; only used after the limit compare, so they never wrap mid-scan.
    always_comb begin
        r_inc = r_q + ROW_W'(1);
        c_inc = c_q + COL_W'(1);
    end

    // Abort request is tied low when the feature is not built in.
`ifdef LOOP_SCAN_ABORT_EN
    always_comb abort_req = abort;
`else
    always_comb abort_req = 1'b0;
`endif

    // Next-state and next-output logic; last is precomputed so it is registered with its element.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        row_max_d = row_max_q;
        col_max_d = col_max_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    row_max_d = row_max;
                    col_max_d = col_max;
                    r_d       = '0;
                    c_d       = '0;
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    last_d    = (row_max == '0) && (col_max == '0);
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_d = IDLE;
                    r_d     = '0;
                    c_d     = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (!stall) begin
                    if (c_q != col_max_q) begin
                        c_d    = c_inc;
                        last_d = (r_q == row_max_q) && (c_inc == col_max_q);
                    end else if (r_q != row_max_q) begin
                        c_d    = '0;
                        r_d    = r_inc;
                        last_d = (r_inc == row_max_q) && (col_max_q == '0);
                    end else begin
                        // Final element consumed: indices hold their last values.
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            c_q       <= '0;
            row_max_q <= '0;
            col_max_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            row_max_q <= row_max_d;
            col_max_q <= col_max_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign r     = r_q;
    assign c     = c_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/loop_scan_ctrl.md
Name: loop_scan_ctrl

Overview:
- Sequencer for the row/column loop datapath: on a start command it walks a 2-D index space (r outer, c inner) from (0,0) to (row_max,col_max).
- Presents one (r,c) element per cycle under valid/stall flow control, then pulses done.
- Sits between the top-level control and the nested row/column counter datapath; owns loop limits and the start/done handshake.

Parameters:
- ROW_W, 4, width of row index and row_max
- COL_W, 4, width of column index and col_max

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a scan; sampled only in IDLE
- row_max  in  ROW_W  last row index (inclusive); latched on accepted start
- col_max  in  COL_W  last column index (inclusive); latched on accepted start
- stall  in  1  downstream hold; element does not advance while high
- r  out  ROW_W  current row index
- c  out  COL_W  current column index
- valid  out  1  (r,c) is a live element
- last  out  1  current element is (row_max,col_max)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after the final element is consumed

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst). All outputs registered.
- Reset (any state, including mid-scan): state=IDLE, r=0, c=0, valid=0, last=0, busy=0, done=0. Latched limits cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge N latches row_max/col_max.
  - At N+1: state=RUN, r=0, c=0, valid=1, busy=1.
- RUN, element consumed on an edge where valid=1 and stall=0:
  - If c != col_max_q: c <= c+1.
  - If c == col_max_q and r != row_max_q: c <= 0, r <= r+1.
  - If both at max: state <= DONE, valid <= 0, busy <= 0, done <= 1. r and c hold their last values.
- RUN with stall=1: r, c, valid and last hold.
- last = valid && (r==row_max_q) && (c==col_max_q).
- DONE: lasts exactly one cycle with done=1, then IDLE with done=0.
- start is ignored in RUN and DONE. The earliest new start is the first IDLE cycle.
- Latency: start edge to first valid = 1 cycle. Last consume to done = 1 cycle.
- Stall-free scan produces (row_max_q+1)*(col_max_q+1) valid cycles.
- row_max/col_max changes during RUN have no effect (latched copies are used).
- Limits of 0,0 produce a single element with last=1 on its only valid cycle.
- Index arithmetic is unsigned, width-exact. No wrap occurs inside a scan, because the limit compare precedes the increment.
- All-ones limits (15,15) produce 256 elements.

Optional Feature:
- Macro LOOP_SCAN_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in RUN: next cycle state=IDLE, valid=0, last=0, busy=0, r=0, c=0, and no done pulse.
  - abort has priority over stall and element advance.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port; a scan always runs to completion or until rst.

Test Plan:
- 2x2 scan: row_max=1, col_max=1, start pulsed at cycle 0, stall=0.
  - Cycles 1–4: valid=1 with (r,c) = (0,0),(0,1),(1,0),(1,1).
  - last=1 only at cycle 4.
  - Cycle 5: done=1, busy=0. Cycle 6: IDLE.
- Stall: row_max=0, col_max=2, stall=1 during cycles 2–3.
  - (0,1) held for cycles 2–4; (0,2) at cycle 5 with last=1; done at cycle 6.
- Single element: row_max=0, col_max=0.
  - Cycle 1: valid=1, last=1, (0,0). Cycle 2: done=1.
- Start during busy: second start at cycle 2 of a 1x3 scan is ignored.
  - Exactly 3 valid cycles and 1 done pulse; limits changed at cycle 2 have no effect.
- Reset mid-scan: rst=1 at cycle 3 of a 4x4 scan.
  - Next cycle: all outputs 0, state IDLE, no done pulse.
  - A new start then restarts from (0,0).
- LOOP_SCAN_ABORT_EN: abort=1 at (1,2) of a 3x4 scan.
  - Next cycle: valid=0, busy=0, r=0, c=0; done never asserts.
